alu_exec_mc: RTL and testbench

//  Multi-cycle integer ALU: consumes the 5-bit alu_ctrl code produced by the
//  RV32I ALU-control decoder, plus two operands, and returns the result.

---
 rtl/alu_exec_mc.sv | 186 ++++++++++++++++++
 tb/tb_alu_exec_mc.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_mc.sv
// alu_exec_mc: multi-cycle RV32I EX-stage ALU with iterative shifter.
// Ports: clk, rst_n (sync, active low); in_valid/in_ready + alu_ctrl,
//   op_a, op_b (input side); out_valid/out_ready + result, zero, err
//   (output side). Logic/arith ops take 1 cycle, shifts SHIFT_STEP bits
//   per cycle; err flags an illegal alu_ctrl code.
module alu_exec_mc #(
   parameter int XLEN       = 32,
   parameter int SHIFT_STEP = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      alu_ctrl,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            err
);

   localparam int SW = $clog2(XLEN);
   localparam logic [SW-1:0] STEP = SW'(SHIFT_STEP);

   localparam logic [4:0] C_ADD  = 5'b00000;
   localparam logic [4:0] C_SUB  = 5'b10000;
   localparam logic [4:0] C_AND  = 5'b00001;
   localparam logic [4:0] C_OR   = 5'b00010;
   localparam logic [4:0] C_XOR  = 5'b00011;
   localparam logic [4:0] C_SLL  = 5'b00100;
   localparam logic [4:0] C_SRL  = 5'b00101;
   localparam logic [4:0] C_SRA  = 5'b00110;
   localparam logic [4:0] C_SLT  = 5'b10111;
   localparam logic [4:0] C_SLTU = 5'b11000;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} sh_t;

   state_t state, state_nx;
   sh_t    sh_sel, sh_q;

   logic            accept;
   logic            legal;
   logic            is_shift;
   logic [SW-1:0]   shamt;
   logic [XLEN-1:0] alu_val;

   logic [XLEN-1:0] work_q;
   logic [XLEN-1:0] shifted;
   logic [SW-1:0]   rem_q;
   logic [SW-1:0]   step_n;
   logic            last_step;

   logic            load_sh;
   logic            load_res;
   logic [XLEN-1:0] res_nx;
   logic            zero_nx;
   logic            err_nx;

   assign in_ready  = (state == IDLE) && rst_n;
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;
   assign shamt     = op_b[SW-1:0];

   // Single-cycle ops; shift codes yield op_a, which is the
   // correct answer when shamt is zero.
   always_comb begin
      alu_val  = '0;
      legal    = 1'b1;
      is_shift = 1'b0;
      sh_sel   = SH_LL;
      unique case (alu_ctrl)
         C_ADD:  alu_val = op_a + op_b;
         C_SUB:  alu_val = op_a - op_b;
         C_AND:  alu_val = op_a & op_b;
         C_OR:   alu_val = op_a | op_b;
         C_XOR:  alu_val = op_a ^ op_b;
         C_SLL: begin
            alu_val  = op_a;
            is_shift = 1'b1;
            sh_sel   = SH_LL;
         end
         C_SRL: begin
            alu_val  = op_a;
            is_shift = 1'b1;
            sh_sel   = SH_RL;
         end
         C_SRA: begin
            alu_val  = op_a;
            is_shift = 1'b1;
            sh_sel   = SH_RA;
         end
         C_SLT: alu_val = {{(XLEN-1){1'b0}},
                           ($signed(op_a) < $signed(op_b))};
         C_SLTU: alu_val = {{(XLEN-1){1'b0}}, (op_a < op_b)};
         default: legal = 1'b0;
      endcase
   end

   // Last partial step may be shorter than SHIFT_STEP.
   assign step_n    = (rem_q < STEP) ? rem_q : STEP;
   assign last_step = (rem_q <= STEP);

   // The working reg keeps the sign bit of op_a for SRA,
   // so an arithmetic shift of it fills with the captured MSB.
   always_comb begin
      shifted = work_q;
      unique case (sh_q)
         SH_LL:   shifted = work_q << step_n;
         SH_RL:   shifted = work_q >> step_n;
         SH_RA:   shifted = XLEN'($signed(work_q) >>> step_n);
         default: shifted = work_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      load_sh  = 1'b0;
      load_res = 1'b0;
      res_nx   = result;
      zero_nx  = zero;
      err_nx   = err;
      unique case (state)
         IDLE: begin
            if (accept) begin
               if (is_shift && (shamt != '0)) begin
                  state_nx = SHIFT;
                  load_sh  = 1'b1;
               end else begin
                  state_nx = DONE;
                  load_res = 1'b1;
                  res_nx   = legal ? alu_val : '0;
                  zero_nx  = legal ? (alu_val == '0) : 1'b1;
                  err_nx   = !legal;
               end
            end
         end
         SHIFT: begin
            if (last_step) begin
               state_nx = DONE;
               load_res = 1'b1;
               res_nx   = shifted;
               zero_nx  = (shifted == '0);
               err_nx   = 1'b0;
            end
         end
         DONE: begin
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         result <= '0;
         zero   <= 1'b0;
         err    <= 1'b0;
         work_q <= '0;
         rem_q  <= '0;
         sh_q   <= SH_LL;
      end else begin
         if (load_sh) begin
            work_q <= op_a;
            rem_q  <= shamt;
            sh_q   <= sh_sel;
         end else if (state == SHIFT) begin
            work_q <= shifted;
            rem_q  <= rem_q - step_n;
         end
         if (load_res) begin
            result <= res_nx;
            zero   <= zero_nx;
            err    <= err_nx;
         end
      end
   end

endmodule

// File: tb/tb_alu_exec_mc.sv
// tb_alu_exec_mc: scoreboard bench for alu_exec_mc (XLEN 32, STEP 1).
// Expected results are queued at issue and popped when out_valid rises.
module tb_alu_exec_mc;

   localparam int XLEN = 32;
   localparam int STEP = 1;

   localparam logic [4:0] ADD  = 5'b00000;
   localparam logic [4:0] SUB  = 5'b10000;
   localparam logic [4:0] AND_ = 5'b00001;
   localparam logic [4:0] OR_  = 5'b00010;
   localparam logic [4:0] XOR_ = 5'b00011;
   localparam logic [4:0] SLL  = 5'b00100;
   localparam logic [4:0] SRL  = 5'b00101;
   localparam logic [4:0] SRA  = 5'b00110;
   localparam logic [4:0] SLT  = 5'b10111;
   localparam logic [4:0] SLTU = 5'b11000;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [4:0]      alu_ctrl = '0;
   logic [XLEN-1:0] op_a = '0;
   logic [XLEN-1:0] op_b = '0;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic [XLEN-1:0] result;
   logic            zero;
   logic            err;

   typedef struct packed {
      logic [31:0] r;
      logic        z;
      logic        e;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail = 0;

   alu_exec_mc #(.XLEN(XLEN), .SHIFT_STEP(STEP)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_ctrl  (alu_ctrl),
      .op_a      (op_a),
      .op_b      (op_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .err       (err)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [4:0] c,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
      exp_t x;
      x.e = 1'b0;
      case (c)
         ADD:  x.r = a + b;
         SUB:  x.r = a - b;
         AND_: x.r = a & b;
         OR_:  x.r = a | b;
         XOR_: x.r = a ^ b;
         SLL:  x.r = a << b[4:0];
         SRL:  x.r = a >> b[4:0];
         SRA:  x.r = 32'($signed(a) >>> b[4:0]);
         SLT:  x.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         SLTU: x.r = (a < b) ? 32'd1 : 32'd0;
         default: begin
            x.r = '0;
            x.e = 1'b1;
         end
      endcase
      x.z = (x.r == 32'd0);
      return x;
   endfunction

   function automatic int exp_lat(input logic [4:0] c,
                                  input logic [31:0] b);
      int sh;
      sh = int'(b[4:0]);
      if ((c == SLL) || (c == SRL) || (c == SRA))
         return 1 + (sh + STEP - 1) / STEP;
      return 1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [4:0] c,
                       input logic [31:0] a,
                       input logic [31:0] b);
      int k;
      k = 0;
      while (!in_ready && k < 300) begin
         step();
         k++;
      end
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL send_ready got %b want 1", in_ready);
      end
      alu_ctrl = c;
      op_a     = a;
      op_b     = b;
      in_valid = 1'b1;
      sb.push_back(model(c, a, b));
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 1;
      while (!out_valid && lat < 300) begin
         step();
         lat++;
      end
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      in_valid = 1'b1;
      alu_ctrl = ADD;
      op_a     = 32'd1;
      op_b     = 32'd2;
      step();
      step();
      n_checks++;
      if ({in_ready, out_valid, result, zero, err} !== '0) begin
         n_fail++;
         $display("FAIL reset_state got rdy=%b ov=%b r=%h z=%b e=%b want 0",
                  in_ready, out_valid, result, zero, err);
      end
      in_valid = 1'b0;
      rst_n    = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release in_ready got %b want 1", in_ready);
      end
      step();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_no_out out_valid got %b want 0", out_valid);
      end
   endtask

   task automatic run_table(input string nm, input logic [4:0] c,
                            input logic [31:0] a, input logic [31:0] b);
      int   lat;
      exp_t e;
      send(c, a, b);
      wait_out(lat);
      e = sb.pop_front();
      n_checks++;
      if (lat != exp_lat(c, b) || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL %s latency got %0d want %0d", nm, lat, exp_lat(c, b));
      end
      n_checks++;
      if ({result, zero, err} !== {e.r, e.z, e.e}) begin
         n_fail++;
         $display("FAIL %s out got r=%h z=%b e=%b want r=%h z=%b e=%b",
                  nm, result, zero, err, e.r, e.z, e.e);
      end
      step();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s handshake got ov=%b rdy=%b want 0 1",
                  nm, out_valid, in_ready);
      end
   endtask

   task automatic test_arith();
      logic [4:0]  c_t[8] = '{ADD, SUB, SUB, AND_, OR_, XOR_, ADD, SUB};
      logic [31:0] a_t[8] = '{32'd5, 32'd3, 32'd0, 32'hF0F0FF00,
                              32'h12340000, 32'hDEADBEEF,
                              32'hFFFFFFFF, 32'h80000000};
      logic [31:0] b_t[8] = '{32'd7, 32'd3, 32'd1, 32'h0FF0F0F0,
                              32'h00005678, 32'hDEADBEEF,
                              32'd1, 32'd1};
      for (int i = 0; i < 8; i++)
         run_table($sformatf("arith%0d", i), c_t[i], a_t[i], b_t[i]);
      // literal spot checks on the first spec cases
      run_table("add_5_7", ADD, 32'd5, 32'd7);
      n_checks++;
      if (result !== 32'd12) begin
         n_fail++;
         $display("FAIL add_literal got %h want 0000000c", result);
      end
      run_table("sub_0_1", SUB, 32'd0, 32'd1);
      n_checks++;
      if (result !== 32'hFFFFFFFF || zero !== 1'b0) begin
         n_fail++;
         $display("FAIL sub_literal got %h z=%b want ffffffff z=0",
                  result, zero);
      end
   endtask

   task automatic test_shift();
      logic [4:0]  c_t[7] = '{SRA, SRL, SLL, SLL, SRA, SRL, SRA};
      logic [31:0] a_t[7] = '{32'h80000000, 32'h80000000, 32'd1,
                              32'hA5A5A5A5, 32'h9ABC0123,
                              32'hC0FFEE00, 32'h7FFFFFFF};
      logic [31:0] b_t[7] = '{32'h24, 32'h24, 32'd31, 32'h20,
                              32'd7, 32'hFFFFFFE3, 32'd30};
      for (int i = 0; i < 7; i++)
         run_table($sformatf("shift%0d", i), c_t[i], a_t[i], b_t[i]);
      run_table("sra_literal", SRA, 32'h80000000, 32'h24);
      n_checks++;
      if (result !== 32'hF8000000) begin
         n_fail++;
         $display("FAIL sra_literal got %h want f8000000", result);
      end
   endtask

   task automatic test_slt_ignore();
      int   lat;
      int   bad;
      exp_t e;
      run_table("slt", SLT, 32'hFFFFFFFF, 32'd1);
      run_table("sltu", SLTU, 32'hFFFFFFFF, 32'd1);
      run_table("slt_pos", SLT, 32'd1, 32'hFFFFFFFF);
      send(SRL, 32'hF0000000, 32'd6);
      lat = 1;
      bad = 0;
      while (!out_valid && lat < 300) begin
         if (in_ready !== 1'b0) bad++;
         in_valid = lat[0];
         alu_ctrl = ADD;
         op_a     = $urandom;
         op_b     = $urandom;
         step();
         lat++;
      end
      if (in_ready !== 1'b0) bad++;
      in_valid = 1'b0;
      n_checks++;
      if (bad != 0 || lat != 7) begin
         n_fail++;
         $display("FAIL busy_ready got bad=%0d lat=%0d want 0 7", bad, lat);
      end
      e = sb.pop_front();
      n_checks++;
      if ({result, zero, err} !== {e.r, e.z, e.e}) begin
         n_fail++;
         $display("FAIL busy_result got %h want %h", result, e.r);
      end
      step();
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         if (out_valid !== 1'b0) bad++;
         step();
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL busy_no_capture got %0d extra cycles want 0", bad);
      end
   endtask

   task automatic test_backpressure();
      int   lat;
      int   bad;
      exp_t e;
      out_ready = 1'b0;
      send(ADD, 32'd100, 32'd23);
      wait_out(lat);
      e = sb.pop_front();
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         if (out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
         if ({result, zero, err} !== {e.r, e.z, e.e}) bad++;
         step();
      end
      n_checks++;
      if (bad != 0 || result !== 32'd123) begin
         n_fail++;
         $display("FAIL stall_hold got bad=%0d r=%h want 0 0000007b",
                  bad, result);
      end
      out_ready = 1'b1;
      n_checks++;
      if (out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_valid got %b want 1", out_valid);
      end
      step();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd123) begin
         n_fail++;
         $display("FAIL stall_release got ov=%b rdy=%b r=%h want 0 1 7b",
                  out_valid, in_ready, result);
      end
   endtask

   task automatic test_illegal();
      logic [4:0] c_t[4] = '{5'b11111, 5'b01000, 5'b10001, 5'b00111};
      for (int i = 0; i < 4; i++) begin
         run_table($sformatf("illegal%0d", i), c_t[i],
                   32'h12345678, 32'h9);
         n_checks++;
         if (err !== 1'b1 || zero !== 1'b1 || result !== '0) begin
            n_fail++;
            $display("FAIL illegal_flags%0d got e=%b z=%b r=%h want 1 1 0",
                     i, err, zero, result);
         end
      end
   endtask

   task automatic test_reset_mid_shift();
      int bad;
      run_table("pre_reset", ADD, 32'd9, 32'd9);
      send(SLL, 32'd1, 32'd31);
      for (int i = 0; i < 5; i++) step();
      rst_n = 1'b0;
      step();
      sb.delete();
      n_checks++;
      if ({out_valid, in_ready, result, zero, err} !== '0) begin
         n_fail++;
         $display("FAIL midreset got ov=%b rdy=%b r=%h z=%b e=%b want 0",
                  out_valid, in_ready, result, zero, err);
      end
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (out_valid !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL stale_output got %0d cycles want 0", bad);
      end
      run_table("post_reset", XOR_, 32'h0000FFFF, 32'h00FF00FF);
   endtask

   task automatic test_back_to_back();
      logic [4:0] c_t[12] = '{ADD, SUB, AND_, OR_, XOR_, SLL, SRL,
                              SRA, SLT, SLTU, 5'b11111, 5'b01010};
      int   sent;
      int   got;
      int   cyc;
      int   bad;
      int   prev;
      exp_t e;
      sent = 0;
      got  = 0;
      cyc  = 0;
      bad  = 0;
      prev = 0;
      while (got < 10 && cyc < 600) begin
         if (out_valid) begin
            e = sb.pop_front();
            if ({result, zero, err} !== {e.r, e.z, e.e}) begin
               bad++;
               $display("FAIL b2b%0d got %h want %h", got, result, e.r);
            end
            got++;
         end
         if (out_valid && prev != 0) bad++;
         prev = out_valid ? 1 : 0;
         if (in_ready) begin
            if (sent < 10) begin
               alu_ctrl = c_t[$urandom_range(11)];
               op_a     = $urandom;
               op_b     = $urandom;
               in_valid = 1'b1;
               sb.push_back(model(alu_ctrl, op_a, op_b));
               sent++;
            end else begin
               in_valid = 1'b0;
            end
         end
         step();
         cyc++;
      end
      in_valid = 1'b0;
      n_checks++;
      if (got != 10 || bad != 0 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL b2b_stream got=%0d bad=%0d left=%0d want 10 0 0",
                  got, bad, sb.size());
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_arith();
      test_shift();
      test_slt_ignore();
      test_backpressure();
      test_illegal();
      test_reset_mid_shift();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
